// File: rtl/mem_pkg.sv
// mem_pkg: opcodes, access sizes and nop encoding shared by the MEM stage
package mem_pkg;
  typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [31:0] NOP = 32'h0;
  function automatic size_e op_size(input logic [5:0] op);
    return op inside {OP_LW, OP_SW} ? WORD : op inside {OP_LH, OP_LHU, OP_SH} ? HALF : BYTE;
  endfunction
endpackage

// File: rtl/data_memory.sv
// data_memory: DM_WORDS x 32 RAM, byte-enable synchronous write, combinational read,
// asynchronous active-low clear of every word
module data_memory #(
  parameter int DM_WORDS = 4096,
  parameter int AW = $clog2(DM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DM_WORDS];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= '0;
    else for (int b = 0; b < 4; b++) if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MIPS MEM stage (EX/MEM register, loads/stores, load extension).
// Define MEM_ALIGN_CHECK_EN to flag misaligned accesses on addr_err instead of aligning down.
module memory_stage
  import mem_pkg::*;
#(
  parameter int DM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic [31:0] AO,
  input  logic [31:0] rt,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] Inst_out,
  output logic [31:0] AO_out,
  output logic [31:0] DO,
  output logic        DO_reliable,
  output logic        addr_err
);
  localparam int AW = $clog2(DM_WORDS);
  logic [31:0] r_inst, r_ao, r_rt;
  logic [5:0]  w_op;
  size_e       w_size;
  logic        w_load, w_store, w_mis, w_unused;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rdata, w_ld;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {r_inst, r_ao, r_rt} <= '0;
    else if (flush) {r_inst, r_ao, r_rt} <= {NOP, 64'h0};
    else if (!stall) {r_inst, r_ao, r_rt} <= {Inst, AO, rt};
  assign w_op    = r_inst[31:26];
  assign w_size  = op_size(w_op);
  assign w_load  = w_op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
  assign w_store = w_op inside {OP_SW, OP_SB, OP_SH};
`ifdef MEM_ALIGN_CHECK_EN
  assign w_mis = (w_load | w_store) & (w_size == WORD ? |r_ao[1:0] : (w_size == HALF) & r_ao[0]);
`else
  assign w_mis = 1'b0;
`endif
  // Lanes replicate the store data so the byte enable alone selects the target bytes
  assign w_be    = !w_store || w_mis ? 4'h0 : w_size == WORD ? 4'hF :
                   w_size == HALF ? (r_ao[1] ? 4'hC : 4'h3) : 4'h1 << r_ao[1:0];
  assign w_wdata = w_size == WORD ? r_rt : w_size == HALF ? {2{r_rt[15:0]}} : {4{r_rt[7:0]}};
  data_memory #(.DM_WORDS(DM_WORDS), .AW(AW)) u_dm (
    .clk     (clk),
    .reset   (reset),
    .i_addr  (r_ao[AW+1:2]),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );
  assign w_byte = w_rdata[{r_ao[1:0], 3'b000} +: 8];
  assign w_half = r_ao[1] ? w_rdata[31:16] : w_rdata[15:0];
  assign w_ld   = w_mis ? '0 :
                  w_op == OP_LB  ? {{24{w_byte[7]}}, w_byte} :
                  w_op == OP_LBU ? {24'h0, w_byte} :
                  w_op == OP_LH  ? {{16{w_half[15]}}, w_half} :
                  w_op == OP_LHU ? {16'h0, w_half} : w_rdata;
  assign Inst_out    = r_inst;
  assign AO_out      = r_ao;
  assign DO          = w_load ? w_ld : r_ao;
  assign DO_reliable = |r_inst & !w_store;
  assign addr_err    = w_mis;
  assign w_unused    = ^r_ao[31:AW+2];
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: byte-array reference model of the MEM stage plus directed literal checks
module tb_memory_stage;
  localparam int DM_WORDS = 4096;
  localparam int NB = DM_WORDS * 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic        clk = 0, reset = 1, stall = 0, flush = 0;
  logic [31:0] Inst = 0, AO = 0, rt = 0;
  logic [31:0] Inst_out, AO_out, DO;
  logic        DO_reliable, addr_err;
  int          errors = 0, checks = 0;
  logic [31:0] m_inst, m_ao, m_rt;
  logic [7:0]  m_mem [NB];

  always #5 clk = ~clk;

  memory_stage #(.DM_WORDS(DM_WORDS)) dut (
    .clk(clk), .reset(reset), .Inst(Inst), .AO(AO), .rt(rt), .stall(stall), .flush(flush),
    .Inst_out(Inst_out), .AO_out(AO_out), .DO(DO), .DO_reliable(DO_reliable), .addr_err(addr_err)
  );

  function automatic int nbytes(input logic [5:0] op);
    return op inside {6'h23, 6'h2B} ? 4 : op inside {6'h21, 6'h25, 6'h29} ? 2 : 1;
  endfunction
  function automatic bit is_load(input logic [5:0] op);
    return op inside {6'h23, 6'h20, 6'h24, 6'h21, 6'h25};
  endfunction
  function automatic bit is_store(input logic [5:0] op);
    return op inside {6'h2B, 6'h28, 6'h29};
  endfunction
  function automatic bit misaligned();
    logic [5:0] op = m_inst[31:26];
    return ALIGN && (is_load(op) || is_store(op)) && (int'(m_ao % 32'(nbytes(op))) != 0);
  endfunction
  function automatic int eff_addr();
    int a = int'(m_ao % 32'(NB));
    return a - a % nbytes(m_inst[31:26]);
  endfunction
  function automatic logic [31:0] exp_do();
    logic [5:0]  op = m_inst[31:26];
    logic [31:0] v = 0, ones = '1;
    int n = nbytes(op), a = eff_addr();
    if (!is_load(op)) return m_ao;
    if (misaligned()) return 0;
    for (int k = 0; k < n; k++) v |= 32'(m_mem[a + k]) << (8 * k);
    if ((op == 6'h20 || op == 6'h21) && v[8*n-1]) v |= ones << (8 * n);
    return v;
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NB; i++) m_mem[i] <= 0;
      m_inst <= 0; m_ao <= 0; m_rt <= 0;
    end else begin
      if (is_store(m_inst[31:26]) && !misaligned())
        for (int k = 0; k < nbytes(m_inst[31:26]); k++) m_mem[eff_addr() + k] <= m_rt[8*k +: 8];
      if (flush) begin
        m_inst <= 0; m_ao <= 0; m_rt <= 0;
      end else if (!stall) begin
        m_inst <= Inst; m_ao <= AO; m_rt <= rt;
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic compare();
    chk("model Inst_out", Inst_out, m_inst);
    chk("model AO_out", AO_out, m_ao);
    chk("model DO", DO, exp_do());
    chk("model DO_reliable", 32'(DO_reliable), 32'(m_inst != 0 && !is_store(m_inst[31:26])));
    chk("model addr_err", 32'(addr_err), 32'(misaligned()));
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    Inst = {op, 26'h00A5}; AO = a; rt = d;
    step();
  endtask
  task automatic zeros(input string tag);
    chk({tag, " Inst_out"}, Inst_out, 0);
    chk({tag, " AO_out"}, AO_out, 0);
    chk({tag, " DO"}, DO, 0);
    chk({tag, " DO_reliable"}, 32'(DO_reliable), 0);
    chk({tag, " addr_err"}, 32'(addr_err), 0);
  endtask

  initial begin
    #1 reset = 0;
    #2 zeros("reset");
    @(negedge clk) reset = 1;
    issue(6'h2B, 32'h10, 32'h8899AABB);
    issue(6'h23, 32'h10, 0);
    chk("lw after sw", DO, 32'h8899AABB);
    chk("lw reliable", 32'(DO_reliable), 1);
    issue(6'h28, 32'h11, 32'h000000F0);
    issue(6'h23, 32'h10, 0);
    chk("lw after sb", DO, 32'h8899F0BB);
    issue(6'h20, 32'h11, 0);
    chk("lb", DO, 32'hFFFFFFF0);
    issue(6'h24, 32'h11, 0);
    chk("lbu", DO, 32'h000000F0);
    issue(6'h29, 32'h22, 32'h00008001);
    issue(6'h21, 32'h22, 0);
    chk("lh", DO, 32'hFFFF8001);
    issue(6'h25, 32'h22, 0);
    chk("lhu", DO, 32'h00008001);
    issue(6'h23, 32'h20, 0);
    chk("lw after sh", DO, 32'h80010000);
    issue(6'h23, 32'h4010, 0);
    chk("lw wrap", DO, 32'h8899F0BB);
    Inst = 32'h00221821; AO = 32'h1234; rt = 0;
    step();
    Inst = {6'h23, 26'h0}; AO = 32'h20; stall = 1;
    step();
    chk("stall1 AO_out", AO_out, 32'h1234);
    chk("stall1 DO", DO, 32'h1234);
    step();
    chk("stall2 AO_out", AO_out, 32'h1234);
    chk("stall2 DO", DO, 32'h1234);
    flush = 1;
    step();
    chk("flush Inst_out", Inst_out, 0);
    chk("flush DO_reliable", 32'(DO_reliable), 0);
    stall = 0; flush = 0;
    issue(6'h2B, 32'h13, 32'h11223344);
    chk("sw misaligned addr_err", 32'(addr_err), 32'(ALIGN));
    issue(6'h23, 32'h10, 0);
    chk("lw after misaligned sw", DO, ALIGN ? 32'h8899F0BB : 32'h11223344);
    issue(6'h21, 32'h23, 0);
    chk("lh misaligned", DO, ALIGN ? 32'h0 : 32'hFFFF8001);
    chk("lh misaligned addr_err", 32'(addr_err), 32'(ALIGN));
    issue(6'h2B, 32'h30, 32'hDEADBEEF);
    #2 reset = 0;
    #1 zeros("async reset");
    @(negedge clk) reset = 1;
    issue(6'h23, 32'h10, 0);
    chk("lw after reset", DO, 0);
    issue(6'h23, 32'h30, 0);
    chk("lw aborted store", DO, 0);
    Inst = 0; AO = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
